// File: rtl/conway_gen_ctrl.sv
// rtl/conway_gen_ctrl.sv - Game of Life generation sequencer over ping-pong 1-bit grid RAMs
//
// Purpose: scans the grid in raster order. For each cell it reads the 3x3 toroidal
// neighbourhood from the source bank and applies B3/S23. The next state goes to the
// destination bank. The banks swap once the whole grid has been written.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_start        single-cycle request to compute one generation (ignored while busy)
//   o_rd_x/o_rd_y  read address to source bank ({y,x} addressing)
//   i_rd_data      source bank read data, valid the cycle after the address
//   o_we           destination bank write enable
//   o_wr_x/o_wr_y  write address to destination bank
//   o_wr_data      next-state cell value
//   o_bank         source/display bank; reads use bank, writes use ~bank
//   o_busy         high from start acceptance through DONE
//   o_done         one-cycle pulse at end of generation
//   o_gen_count    completed generations, wraps
module conway_gen_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = 10,
    parameter int YW     = 9,
    parameter int CW     = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    output logic [XW-1:0] o_rd_x,
    output logic [YW-1:0] o_rd_y,
    input  logic          i_rd_data,
    output logic          o_we,
    output logic [XW-1:0] o_wr_x,
    output logic [YW-1:0] o_wr_y,
    output logic          o_wr_data,
    output logic          o_bank,
    output logic          o_busy,
    output logic          o_done,
    output logic [CW-1:0] o_gen_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LAST  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    logic [2:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [3:0]    r_k;
    logic [3:0]    r_n;
    logic          r_alive;
    logic [XW-1:0] r_rd_x;
    logic [YW-1:0] r_rd_y;
    logic          r_we;
    logic [XW-1:0] r_wr_x;
    logic [YW-1:0] r_wr_y;
    logic          r_wr_data;
    logic          r_bank;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_gen_count;

    logic [XW-1:0] w_xm1;
    logic [XW-1:0] w_xp1;
    logic [YW-1:0] w_ym1;
    logic [YW-1:0] w_yp1;
    logic [XW-1:0] w_nb_x;
    logic [YW-1:0] w_nb_y;
    logic [3:0]    w_n_acc;
    logic          w_next_alive;
    logic          w_last_cell;

    // Toroidal neighbours by compare/select; the grid size need not be a power of two.
    assign w_xm1 = (r_x == '0)    ? X_MAX : r_x - XW'(1);
    assign w_xp1 = (r_x == X_MAX) ? '0    : r_x + XW'(1);
    assign w_ym1 = (r_y == '0)    ? Y_MAX : r_y - YW'(1);
    assign w_yp1 = (r_y == Y_MAX) ? '0    : r_y + YW'(1);

    // Neighbour k: column from k%3, row from k/3 (k=4 is the cell itself).
    always_comb begin
        w_nb_x = r_x;
        w_nb_y = r_y;
        case (r_k)
            4'd0, 4'd3, 4'd6: w_nb_x = w_xm1;
            4'd2, 4'd5, 4'd8: w_nb_x = w_xp1;
            default:          w_nb_x = r_x;
        endcase
        if (r_k < 4'd3) begin
            w_nb_y = w_ym1;
        end else if (r_k >= 4'd6) begin
            w_nb_y = w_yp1;
        end
    end

    assign w_n_acc      = r_n + {3'b000, i_rd_data};
    assign w_next_alive = (w_n_acc == 4'd3) | (r_alive & (w_n_acc == 4'd2));
    assign w_last_cell  = (r_x == X_MAX) && (r_y == Y_MAX);

    // The read address is live during READ and holds its last value elsewhere.
    assign o_rd_x      = (r_state == S_READ) ? w_nb_x : r_rd_x;
    assign o_rd_y      = (r_state == S_READ) ? w_nb_y : r_rd_y;
    assign o_we        = r_we;
    assign o_wr_x      = r_wr_x;
    assign o_wr_y      = r_wr_y;
    assign o_wr_data   = r_wr_data;
    assign o_bank      = r_bank;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_gen_count = r_gen_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_k         <= '0;
            r_n         <= '0;
            r_alive     <= 1'b0;
            r_rd_x      <= '0;
            r_rd_y      <= '0;
            r_we        <= 1'b0;
            r_wr_x      <= '0;
            r_wr_y      <= '0;
            r_wr_data   <= 1'b0;
            r_bank      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_gen_count <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_READ;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_k     <= '0;
                        r_n     <= '0;
                        r_alive <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    r_rd_x <= w_nb_x;
                    r_rd_y <= w_nb_y;
                    // rd_data carries neighbour k-1; neighbour 4 is the cell itself.
                    if (r_k == 4'd5) begin
                        r_alive <= i_rd_data;
                    end else if (r_k != 4'd0) begin
                        r_n <= w_n_acc;
                    end
                    if (r_k == 4'd8) begin
                        r_state <= S_LAST;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                S_LAST: begin
                    // Neighbour 8 arrives now; register the write so we is high only in WRITE.
                    r_n       <= w_n_acc;
                    r_wr_data <= w_next_alive;
                    r_wr_x    <= r_x;
                    r_wr_y    <= r_y;
                    r_we      <= 1'b1;
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_x == X_MAX) begin
                        r_x <= '0;
                        r_y <= w_yp1;
                    end else begin
                        r_x <= w_xp1;
                    end
                    if (w_last_cell) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_READ;
                        r_k     <= '0;
                        r_n     <= '0;
                        r_alive <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Swap on leaving DONE so bank stays stable for the whole busy window.
                    r_bank      <= ~r_bank;
                    r_gen_count <= r_gen_count + CW'(1);
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conway_gen_ctrl.sv
// tb/tb_conway_gen_ctrl.sv - directed self-checking bench for conway_gen_ctrl
module tb_conway_gen_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 5x5 instance
    logic        rst5, start5, rd_data5, we5, wr_data5, bank5, busy5, done5;
    logic [2:0]  rd_x5, rd_y5, wr_x5, wr_y5;
    logic [15:0] gen5;
    // 4x4 instance
    logic        rst4, start4, rd_data4, we4, wr_data4, bank4, busy4, done4;
    logic [1:0]  rd_x4, rd_y4, wr_x4, wr_y4;
    logic [15:0] gen4;

    conway_gen_ctrl #(.WIDTH(5), .HEIGHT(5), .XW(3), .YW(3), .CW(16)) dut5 (
        .i_clk(clk), .i_reset(rst5), .i_start(start5),
        .o_rd_x(rd_x5), .o_rd_y(rd_y5), .i_rd_data(rd_data5),
        .o_we(we5), .o_wr_x(wr_x5), .o_wr_y(wr_y5), .o_wr_data(wr_data5),
        .o_bank(bank5), .o_busy(busy5), .o_done(done5), .o_gen_count(gen5)
    );

    conway_gen_ctrl #(.WIDTH(4), .HEIGHT(4), .XW(2), .YW(2), .CW(16)) dut4 (
        .i_clk(clk), .i_reset(rst4), .i_start(start4),
        .o_rd_x(rd_x4), .o_rd_y(rd_y4), .i_rd_data(rd_data4),
        .o_we(we4), .o_wr_x(wr_x4), .o_wr_y(wr_y4), .o_wr_data(wr_data4),
        .o_bank(bank4), .o_busy(busy4), .o_done(done4), .o_gen_count(gen4)
    );

    // Ping-pong RAM models, {y,x} addressed, one-cycle registered read.
    logic [63:0] m5 [2];
    logic        ld5;
    logic [63:0] ld5_v0, ld5_v1;
    always @(posedge clk) begin
        if (ld5) begin
            m5[0] <= ld5_v0;
            m5[1] <= ld5_v1;
        end else if (we5) begin
            m5[~bank5][{wr_y5, wr_x5}] <= wr_data5;
        end
        rd_data5 <= m5[bank5][{rd_y5, rd_x5}];
    end

    logic [15:0] m4 [2];
    logic        ld4_0, ld4_1;
    logic [15:0] ld4_v0, ld4_v1;
    always @(posedge clk) begin
        if (ld4_0) m4[0] <= ld4_v0;
        if (ld4_1) m4[1] <= ld4_v1;
        if (we4 && !ld4_0 && !ld4_1) m4[~bank4][{wr_y4, wr_x4}] <= wr_data4;
        rd_data4 <= m4[bank4][{rd_y4, rd_x4}];
    end

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start at "cycle 0", report the cycle of the done pulse (-1 if the budget expires),
    // then settle one more cycle so the bank swap is visible.
    task automatic run(input bit use4, input int budget, output int cyc);
        cyc = -1;
        @(negedge clk);
        if (use4) start4 = 1'b1; else start5 = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            start5 = 1'b0;
            if ((use4 ? done4 : done5) === 1'b1) begin
                cyc = c;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic load5(input logic [63:0] v0, input logic [63:0] v1);
        @(negedge clk);
        ld5 = 1'b1; ld5_v0 = v0; ld5_v1 = v1;
        @(negedge clk);
        ld5 = 1'b0;
    endtask

    localparam logic [63:0] HORIZ = 64'h0000_0000_000E_0000; // (1,2),(2,2),(3,2)
    localparam logic [63:0] VERT  = 64'h0000_0000_0404_0400; // (2,1),(2,2),(2,3)
    localparam logic [63:0] FULL5 = 64'h0000_001F_1F1F_1F1F; // every valid 5x5 cell
    localparam logic [15:0] CORN  = 16'h9009;                // 4x4 corners

    int exp_rx [9] = '{4, 0, 1, 4, 0, 1, 4, 0, 1};
    int exp_ry [9] = '{4, 4, 4, 0, 0, 0, 1, 1, 1};

    int wi, ndone, done_cyc, cyc;

    initial begin
        rst5 = 1'b1; rst4 = 1'b1; start5 = 1'b0; start4 = 1'b0;
        ld5 = 1'b0; ld5_v0 = '0; ld5_v1 = '0;
        ld4_0 = 1'b0; ld4_1 = 1'b0; ld4_v0 = '0; ld4_v1 = '0;
        repeat (2) @(negedge clk);

        chk("rst_busy", busy5, 0);
        chk("rst_done", done5, 0);
        chk("rst_we", we5, 0);
        chk("rst_bank", bank5, 0);
        chk("rst_gen", gen5, 0);
        chk("rst_rd_xy", {rd_y5, rd_x5}, 0);
        chk("rst_wr", {wr_y5, wr_x5, wr_data5}, 0);
        rst5 = 1'b0; rst4 = 1'b0;

        // Blinker with ignored start pulses at cycles 5 and 100.
        load5(HORIZ, FULL5);
        @(negedge clk);
        start5 = 1'b1;
        wi = 0; ndone = 0; done_cyc = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start5 = (c == 5 || c == 100);
            if (c <= 9) begin
                chk($sformatf("rd_x_k%0d", c - 1), rd_x5, exp_rx[c-1]);
                chk($sformatf("rd_y_k%0d", c - 1), rd_y5, exp_ry[c-1]);
            end
            if (c == 5 || c == 100) chk($sformatf("busy_c%0d", c), busy5, 1);
            if (we5) begin
                chk($sformatf("we_cycle_%0d", wi), c, 11 * (wi + 1));
                chk($sformatf("we_addr_%0d", wi), {wr_y5, wr_x5}, ((wi / 5) << 3) | (wi % 5));
                wi++;
            end
            if (done5) begin
                ndone++;
                done_cyc = c;
            end
        end
        start5 = 1'b0;
        chk("we_count", wi, 25);
        chk("done_count", ndone, 1);
        chk("done_cycle", done_cyc, 276);
        chk("blink_bank", bank5, 1);
        chk("blink_gen", gen5, 1);
        chk("blink_busy", busy5, 0);
        chk("blink_dst", m5[1], VERT);
        chk("blink_src", m5[0], HORIZ);

        // Reset mid-generation (source is bank 1 here).
        load5(FULL5, VERT);
        @(negedge clk);
        start5 = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start5 = 1'b0;
        end
        rst5 = 1'b1;
        #1;
        chk("mid_rst_busy", busy5, 0);
        chk("mid_rst_we", we5, 0);
        chk("mid_rst_bank", bank5, 0);
        chk("mid_rst_gen", gen5, 0);
        chk("mid_rst_done", done5, 0);
        @(negedge clk);
        rst5 = 1'b0;
        load5(HORIZ, FULL5);
        run(1'b0, 400, cyc);
        chk("post_rst_cycle", cyc, 276);
        chk("post_rst_dst", m5[1], VERT);
        chk("post_rst_bank", bank5, 1);
        chk("post_rst_gen", gen5, 1);

        // 4x4 wrap still-life, two generations.
        @(negedge clk);
        ld4_0 = 1'b1; ld4_1 = 1'b1; ld4_v0 = CORN; ld4_v1 = 16'hFFFF;
        @(negedge clk);
        ld4_0 = 1'b0; ld4_1 = 1'b0;
        run(1'b1, 300, cyc);
        chk("wrap1_cycle", cyc, 177);
        chk("wrap1_dst", m4[1], CORN);
        chk("wrap1_bank", bank4, 1);
        @(negedge clk);
        ld4_0 = 1'b1; ld4_v0 = 16'hFFFF;
        @(negedge clk);
        ld4_0 = 1'b0;
        run(1'b1, 300, cyc);
        chk("wrap2_cycle", cyc, 177);
        chk("wrap2_dst", m4[0], CORN);
        chk("wrap2_src", m4[1], CORN);
        chk("wrap2_bank", bank4, 0);
        chk("wrap2_gen", gen4, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conway_gen_ctrl.md
Name: conway_gen_ctrl

Overview:
- Sequences one Game of Life generation across a pair of 1-bit dual-port grid RAMs (ping-pong banks, each 2^(YW+XW) deep, addressed {y,x}, 1-cycle registered read).
- Scans the grid in raster order. For each cell it reads the 3x3 toroidal neighbourhood from the source bank, applies the B3/S23 rule, and writes the result to the destination bank.
- When the whole grid is written, it swaps banks so the display side reads the new generation.

Parameters:
- WIDTH, 640, grid columns (x range 0..WIDTH-1)
- HEIGHT, 480, grid rows (y range 0..HEIGHT-1)
- XW, 10, x address width
- YW, 9, y address width
- CW, 16, generation counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to compute one generation
- rd_x  out  XW  read column to source bank
- rd_y  out  YW  read row to source bank
- rd_data  in  1  source bank registered read data; valid the cycle after the address is presented
- we  out  1  write enable to destination bank
- wr_x  out  XW  write column
- wr_y  out  YW  write row
- wr_data  out  1  next-state cell value
- bank  out  1  source/display bank; reads go to bank, writes to ~bank
- busy  out  1  high from start acceptance through DONE inclusive
- done  out  1  one-cycle pulse in DONE
- gen_count  out  CW  completed generations, wraps modulo 2^CW

Behaviour:
- Reset (async, any state): state=IDLE; rd_x, rd_y, wr_x, wr_y, wr_data, we, bank, busy, done, gen_count, cell x/y, k and n all 0.
- States: IDLE, READ, LAST, WRITE, DONE.
- IDLE: start=1 -> READ with cell=(0,0), k=0, n=0. busy rises on that same edge. start in any other state is ignored, with no queuing.
- READ (k=0..8):
  - rd_x/rd_y present neighbour k of the current cell, where dy=k/3-1 and dx=k%3-1 (k=4 is the cell itself).
  - For k>=1, rd_data holds neighbour k-1. If that neighbour is not k-1=4, add it to n (4-bit, max 8). If k-1=4, latch it as alive.
  - k=8 -> LAST.
- LAST: accumulate neighbour 8, then -> WRITE.
- WRITE:
  - we=1 for exactly this cycle.
  - wr_x/wr_y = current cell.
  - wr_data = (n==3) | (alive & n==2).
  - Then advance the cell: x+1; at x=WIDTH-1, x=0 and y+1.
  - If the cell just written was (WIDTH-1, HEIGHT-1) -> DONE. Otherwise -> READ with k=0 and n cleared.
- DONE (1 cycle): done=1, bank toggles, gen_count+1. Then -> IDLE and busy falls.
- Toroidal wrap:
  - x-1 at x=0 gives WIDTH-1; x+1 at WIDTH-1 gives 0.
  - y-1 at y=0 gives HEIGHT-1; y+1 at HEIGHT-1 gives 0.
  - Computed by compare/select, never by modulo on the power-of-2 width.
- Per cell: 11 cycles (9 READ + LAST + WRITE). A generation takes 11*WIDTH*HEIGHT + 1 cycles from the first READ through DONE.
- we is 0 in all states except WRITE. rd_x/rd_y hold their last value outside READ.
- The source bank is never written. bank is stable during busy.
- Reset mid-generation: the destination bank is left partially written, bank returns to 0, and no done pulse is issued.

Test Plan:
- Bench setup: two RAM models with 1-cycle read latency, ported per the interface, WIDTH=5, HEIGHT=5.
- Blinker: bank0 alive at (1,2),(2,2),(3,2); start at cycle 0 -> done pulses at cycle 276. Bank1 is alive only at (2,1),(2,2),(2,3). bank=1, gen_count=1.
- Wrap still-life: WIDTH=4, HEIGHT=4, alive at (0,0),(3,0),(0,3),(3,3) -> after one generation, the destination holds the same 4 cells and all others are 0. A second start writes them back to bank0 and bank=0.
- Write sequence: any pattern -> exactly WIDTH*HEIGHT we pulses, addresses in raster order (0,0),(1,0),...,(4,4), spaced 11 cycles apart. rd_x/rd_y of the first 9 READ cycles are (4,4),(0,4),(1,4),(4,0),(0,0),(1,0),(4,1),(0,1),(1,1).
- start pulsed at cycles 5 and 100 while busy -> ignored. Exactly one done pulse, gen_count=1.
- Reset asserted at cycle 50 mid-generation -> immediately state IDLE, we=0, busy=0, bank=0, gen_count=0. A subsequent start runs a full, correct generation.
